alu_4b: RTL and testbench

- Registered 4-bit (parameterisable) arithmetic/logic unit with zero, carry and sign flags.
- Combinational result is captured into output registers on each rising clock edge.
- Sits in the datapath between operand sources and result/flag consumers.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_core_comb.sv | 116 +++++++++++
 rtl/alu_4b.sv | 73 +++++++
 tb/tb_alu_4b.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared encodings and types for the registered ALU (alu_4b) and its
//   combinational core (alu_core_comb).
//
//   Contents:
//     - Operation codes for arithmetic mode (OP_NEG_B, OP_NEG_A, OP_SUB, OP_ADD)
//     - Operation codes for logic mode (OP_AND, OP_OR, OP_XOR, OP_NOT_A).
//       These reuse the arithmetic codes; the mode bit tells them apart.
//     - Mode constants MODE_ARITH / MODE_LOGIC for the 'l' input.
//     - alu_flags_t: packed zero/carry/sign flag bundle and its reset value.
// -----------------------------------------------------------------------------
package alu_pkg;

   // Arithmetic-mode operation select (l = MODE_ARITH)
   localparam logic [1:0] OP_NEG_B = 2'b00;   // -b
   localparam logic [1:0] OP_NEG_A = 2'b01;   // -a
   localparam logic [1:0] OP_SUB   = 2'b10;   // a - b
   localparam logic [1:0] OP_ADD   = 2'b11;   // a + b

   // Logic-mode operation select (l = MODE_LOGIC)
   localparam logic [1:0] OP_AND   = 2'b00;   // a & b
   localparam logic [1:0] OP_OR    = 2'b01;   // a | b
   localparam logic [1:0] OP_XOR   = 2'b10;   // a ^ b
   localparam logic [1:0] OP_NOT_A = 2'b11;   // ~a, b ignored

   // Mode select
   localparam logic MODE_ARITH = 1'b0;
   localparam logic MODE_LOGIC = 1'b1;

   // Status flags carried alongside the result
   typedef struct packed {
      logic z;   // result is zero
      logic c;   // carry-out (arithmetic only)
      logic s;   // sign = result MSB (arithmetic only)
   } alu_flags_t;

   // Reset state: result is zero, so the zero flag is set
   localparam alu_flags_t FLAGS_RESET = '{z: 1'b1, c: 1'b0, s: 1'b0};

endpackage : alu_pkg

// File: rtl/alu_core_comb.sv
// -----------------------------------------------------------------------------
// alu_core_comb
//   Purely combinational ALU datapath. Produces the next result and flags
//   from the current operands; the caller registers them.
//
//   Parameters:
//     WIDTH     operand/result width in bits (>= 2)
//
//   Ports:
//     a         in   WIDTH  operand A
//     b         in   WIDTH  operand B
//     op        in   2      operation select (see alu_pkg)
//     l         in   1      mode: 0 = arithmetic, 1 = logic
//     r_next    out  WIDTH  result
//     flags_next out 3      {z, c, s} flags for r_next
// -----------------------------------------------------------------------------
module alu_core_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             l,
   output logic [WIDTH-1:0] r_next,
   output alu_flags_t       flags_next
);

   // ------------------------------------------------------------------
   // Arithmetic path
   //   Every arithmetic op is folded onto one (WIDTH+1)-bit adder:
   //     sum = add_x + add_y + add_cin
   //   Two's-complement negation / subtraction use the inverted operand
   //   zero-extended plus a carry-in of 1, so sum[WIDTH] is the carry
   //   flag directly:
   //     ADD   : carry-out of a + b
   //     SUB   : a + ~b + 1 carries iff a >= b (no borrow)
   //     NEG_A : ~a + 1 carries only when ~a is all ones, i.e. a == 0
   //     NEG_B : ~b + 1 carries only when b == 0
   // ------------------------------------------------------------------
   logic [WIDTH:0] add_x;
   logic [WIDTH:0] add_y;
   logic           add_cin;
   logic [WIDTH:0] sum;

   always_comb begin
      add_x   = {1'b0, a};
      add_y   = {1'b0, b};
      add_cin = 1'b0;
      case (op)
         OP_ADD: begin
            add_x   = {1'b0, a};
            add_y   = {1'b0, b};
            add_cin = 1'b0;
         end
         OP_SUB: begin
            add_x   = {1'b0, a};
            add_y   = {1'b0, ~b};
            add_cin = 1'b1;
         end
         OP_NEG_A: begin
            add_x   = {1'b0, ~a};
            add_y   = '0;
            add_cin = 1'b1;
         end
         OP_NEG_B: begin
            add_x   = {1'b0, ~b};
            add_y   = '0;
            add_cin = 1'b1;
         end
         default: begin
            add_x   = {1'b0, a};
            add_y   = {1'b0, b};
            add_cin = 1'b0;
         end
      endcase
   end

   assign sum = add_x + add_y + {{WIDTH{1'b0}}, add_cin};

   // ------------------------------------------------------------------
   // Logic path: one bit-slice per result bit
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] logic_r;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_logic_bit
         assign logic_r[gi] = (op == OP_AND) ? (a[gi] & b[gi]) :
                              (op == OP_OR)  ? (a[gi] | b[gi]) :
                              (op == OP_XOR) ? (a[gi] ^ b[gi]) :
                                               ~a[gi];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Result and flag selection
   //   Carry and sign are forced low in logic mode; zero applies to both.
   // ------------------------------------------------------------------
   always_comb begin
      r_next       = sum[WIDTH-1:0];
      flags_next   = FLAGS_RESET;
      if (l == MODE_LOGIC) begin
         r_next       = logic_r;
         flags_next.c = 1'b0;
         flags_next.s = 1'b0;
      end else begin
         r_next       = sum[WIDTH-1:0];
         flags_next.c = sum[WIDTH];
         flags_next.s = sum[WIDTH-1];
      end
      flags_next.z = (r_next == '0);
   end

endmodule : alu_core_comb

// File: rtl/alu_4b.sv
// -----------------------------------------------------------------------------
// alu_4b
//   Registered arithmetic/logic unit. The combinational core result and its
//   zero/carry/sign flags are captured on every rising clock edge, giving a
//   fixed one-cycle latency and a new operation accepted each cycle.
//
//   Parameters:
//     WIDTH   operand/result width in bits (>= 2), default 4
//
//   Ports:
//     clk     in   1      system clock, rising edge
//     rst_n   in   1      synchronous active-low reset; overrides the
//                         operation presented in the same cycle
//     a       in   WIDTH  operand A
//     b       in   WIDTH  operand B
//     op      in   2      operation select (see alu_pkg)
//     l       in   1      mode: 0 = arithmetic, 1 = logic
//     r       out  WIDTH  registered result   (reset 0)
//     z       out  1      registered zero flag  (reset 1)
//     c       out  1      registered carry flag (reset 0)
//     s       out  1      registered sign flag  (reset 0)
// -----------------------------------------------------------------------------
module alu_4b
   import alu_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             l,
   output logic [WIDTH-1:0] r,
   output logic             z,
   output logic             c,
   output logic             s
);

   logic [WIDTH-1:0] r_next;
   alu_flags_t       flags_next;

   logic [WIDTH-1:0] r_reg;
   alu_flags_t       flags_reg;

   alu_core_comb #(
      .WIDTH (WIDTH)
   ) u_core (
      .a          (a),
      .b          (b),
      .op         (op),
      .l          (l),
      .r_next     (r_next),
      .flags_next (flags_next)
   );

   // Output register stage; outputs hold between edges.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_reg     <= '0;
         flags_reg <= FLAGS_RESET;
      end else begin
         r_reg     <= r_next;
         flags_reg <= flags_next;
      end
   end

   assign r = r_reg;
   assign z = flags_reg.z;
   assign c = flags_reg.c;
   assign s = flags_reg.s;

endmodule : alu_4b

// File: tb/tb_alu_4b.sv
// -----------------------------------------------------------------------------
// tb_alu_4b
//   Self-checking bench for alu_4b (WIDTH = 4). The driver applies one
//   operation per cycle on the falling edge and pushes the expected response
//   into a queue; the monitor pops one entry after every rising edge and
//   compares it with r/z/c/s.
// -----------------------------------------------------------------------------
module tb_alu_4b;

   localparam int W = 4;
   localparam int M = 1 << W;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [1:0]   op;
   logic         l;
   logic [W-1:0] r;
   logic         z;
   logic         c;
   logic         s;

   alu_4b #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .op    (op),
      .l     (l),
      .r     (r),
      .z     (z),
      .c     (c),
      .s     (s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] r;
      logic         z;
      logic         c;
      logic         s;
      string        name;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: plain integer arithmetic on the operation definitions.
   function automatic exp_t model(input bit rstn, input bit lm, input int opc,
                                  input int av, input int bv, input string nm);
      exp_t e;
      int   v;
      e.name = nm;
      if (!rstn) begin
         e.r = '0; e.z = 1'b1; e.c = 1'b0; e.s = 1'b0;
         return e;
      end
      if (!lm) begin
         case (opc)
            3:       begin v = av + bv;         e.c = (v >= M);  end
            2:       begin v = av - bv + M;     e.c = (av >= bv); end
            1:       begin v = M - av;          e.c = (av == 0); end
            default: begin v = M - bv;          e.c = (bv == 0); end
         endcase
         v   = v % M;
         e.r = W'(v);
         e.s = (v >= M / 2);
      end else begin
         case (opc)
            0:       v = av & bv;
            1:       v = av | bv;
            2:       v = av ^ bv;
            default: v = (M - 1) - av;
         endcase
         e.r = W'(v);
         e.c = 1'b0;
         e.s = 1'b0;
      end
      e.z = (e.r == 0);
      return e;
   endfunction

   // Drive inputs for the next rising edge and queue the expected response.
   task automatic drive(input bit rstn, input bit lm, input int opc,
                        input int av, input int bv, input exp_t e);
      @(negedge clk);
      rst_n = rstn;
      l     = lm;
      op    = 2'(opc);
      a     = W'(av);
      b     = W'(bv);
      q.push_back(e);
   endtask

   // Directed vector with explicitly stated expectations.
   task automatic directed(input bit rstn, input bit lm, input int opc,
                           input int av, input int bv,
                           input int er, input bit ez, input bit ec, input bit es,
                           input string nm);
      exp_t e;
      e.r = W'(er); e.z = ez; e.c = ec; e.s = es; e.name = nm;
      drive(rstn, lm, opc, av, bv, e);
   endtask

   // Model-checked vector.
   task automatic modelled(input bit rstn, input bit lm, input int opc,
                           input int av, input int bv, input string nm);
      drive(rstn, lm, opc, av, bv, model(rstn, lm, opc, av, bv, nm));
   endtask

   // Monitor: one output transaction per rising edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (r !== e.r || z !== e.z || c !== e.c || s !== e.s) begin
            errors++;
            $display("FAIL %s: got r=%h z=%b c=%b s=%b, expected r=%h z=%b c=%b s=%b",
                     e.name, r, z, c, s, e.r, e.z, e.c, e.s);
         end else begin
            $display("ok   %s: r=%h z=%b c=%b s=%b", e.name, r, z, c, s);
         end
      end
   end

   initial begin
      int wait_cycles;
      rst_n = 1'b0; l = 1'b0; op = 2'b11; a = 4'hF; b = 4'h1;

      // Reset held for two cycles with an ADD presented, then released
      directed(0, 0, 3, 15, 1, 0, 1, 0, 0, "reset_1");
      directed(0, 0, 3, 15, 1, 0, 1, 0, 0, "reset_2");
      directed(1, 0, 3, 15, 1, 0, 1, 1, 0, "rel_add_f_1");

      // Add
      directed(1, 0, 3, 9, 8, 1, 0, 1, 0, "add_9_8");
      directed(1, 0, 3, 3, 4, 7, 0, 0, 0, "add_3_4");

      // Subtract
      directed(1, 0, 2, 5, 5, 0, 1, 1, 0, "sub_5_5");
      directed(1, 0, 2, 2, 3, 15, 0, 0, 1, "sub_2_3");
      directed(1, 0, 2, 7, 0, 7, 0, 1, 0, "sub_7_0");

      // Negate
      directed(1, 0, 1, 0, 0, 0, 1, 1, 0, "neg_a_0");
      directed(1, 0, 1, 1, 0, 15, 0, 0, 1, "neg_a_1");
      directed(1, 0, 0, 0, 8, 8, 0, 0, 1, "neg_b_8");

      // Logic
      directed(1, 1, 0, 12, 10, 8, 0, 0, 0, "and_c_a");
      directed(1, 1, 1, 12, 10, 14, 0, 0, 0, "or_c_a");
      directed(1, 1, 2, 12, 10, 6, 0, 0, 0, "xor_c_a");
      directed(1, 1, 3, 12, 10, 3, 0, 0, 0, "not_c");
      directed(1, 1, 0, 5, 10, 0, 1, 0, 0, "and_5_a");

      // Exhaustive back-to-back sweep
      for (int lm = 0; lm < 2; lm++)
         for (int opc = 0; opc < 4; opc++)
            for (int av = 0; av < M; av++)
               for (int bv = 0; bv < M; bv++)
                  modelled(1, lm[0], opc, av, bv,
                           $sformatf("sweep l=%0d op=%0d a=%0d b=%0d", lm, opc, av, bv));

      // Random traffic with occasional in-flight resets
      for (int i = 0; i < 300; i++) begin
         bit rr;
         bit lm;
         int opc, av, bv;
         rr  = ($urandom_range(0, 15) != 0);
         lm  = 1'($urandom_range(0, 1));
         opc = int'($urandom_range(0, 3));
         av  = int'($urandom_range(0, M - 1));
         bv  = int'($urandom_range(0, M - 1));
         modelled(rr, lm, opc, av, bv,
                  $sformatf("rand rst_n=%0d l=%0d op=%0d a=%0d b=%0d", rr, lm, opc, av, bv));
      end

      // Drain the scoreboard with a bounded wait
      wait_cycles = 0;
      while (q.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         #2;
         wait_cycles++;
      end
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expected responses left, required 0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_alu_4b
